// File: rtl/booth_seq_mul_pkg.sv
// booth_seq_mul_pkg: shared FSM states, Booth digit-select codes and recoder
package booth_seq_mul_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
    typedef enum logic [2:0] {SEL_ZERO = 3'd0, SEL_P1 = 3'd1, SEL_N1 = 3'd2, SEL_P2 = 3'd3, SEL_N2 = 3'd4} sel_t;
    function automatic sel_t booth_recode(input logic [2:0] w);
        return (w == 3'b011) ? SEL_P2 :
               (w == 3'b100) ? SEL_N2 :
               (w == 3'b001 || w == 3'b010) ? SEL_P1 :
               (w == 3'b101 || w == 3'b110) ? SEL_N1 : SEL_ZERO;
    endfunction
endpackage

// File: rtl/booth_digit_sel.sv
// booth_digit_sel: maps one 3-bit Booth window and the multiplicand to a partial product
// BOOTH_SIGNED_EN defined: multiplicand is sign-extended, otherwise zero-extended.
// Negative digits return the one's complement with o_neg set; the +1 is added by the caller.
module booth_digit_sel
    import booth_seq_mul_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic [2:0]       i_win,
    input  logic [WIDTH-1:0] i_a,
    output logic [WIDTH+1:0] o_pp,
    output logic             o_neg
);
    sel_t             w_sel;
    logic [WIDTH+1:0] w_a1;
    logic [WIDTH+1:0] w_mag;
    // select magnitude (0, A or 2A) then conditionally invert for negative digits
    always_comb begin
        w_sel = booth_recode(i_win);
`ifdef BOOTH_SIGNED_EN
        w_a1  = {{2{i_a[WIDTH-1]}}, i_a};
`else
        w_a1  = {2'b00, i_a};
`endif
        w_mag = (w_sel == SEL_P2 || w_sel == SEL_N2) ? {w_a1[WIDTH:0], 1'b0} :
                (w_sel == SEL_ZERO) ? '0 : w_a1;
        o_neg = (w_sel == SEL_N1 || w_sel == SEL_N2);
        o_pp  = o_neg ? ~w_mag : w_mag;
    end
endmodule

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: iterative radix-4 Booth multiplier, one digit per cycle, valid/ready handshake
// BOOTH_SIGNED_EN defined: a and b are two's complement, otherwise unsigned.
module booth_seq_mul
    import booth_seq_mul_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int NDIG = WIDTH / 2 + 1;
    localparam int CW   = $clog2(NDIG);
    localparam int AW   = 2 * WIDTH + 2;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH+2:0]   r_mreg;
    logic [AW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;
    logic [WIDTH+1:0]   w_pp;
    logic               w_neg;
    logic               w_ext;
    logic [AW-1:0]      w_pp_ext;
    logic [AW-1:0]      w_acc_next;

    booth_digit_sel #(.WIDTH(WIDTH)) u_sel (
        .i_win (r_mreg[2:0]),
        .i_a   (r_a),
        .o_pp  (w_pp),
        .o_neg (w_neg)
    );

    // multiplier extension bit and the shifted accumulate (neg carry folded into the same add)
    always_comb begin
`ifdef BOOTH_SIGNED_EN
        w_ext      = b[WIDTH-1];
`else
        w_ext      = 1'b0;
`endif
        w_pp_ext   = {{(AW-WIDTH-2){w_pp[WIDTH+1]}}, w_pp};
        w_acc_next = r_acc + (w_pp_ext << {r_cnt, 1'b0}) + (AW'(w_neg) << {r_cnt, 1'b0});
    end

    // control FSM with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_mreg      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a        <= a;
                    r_mreg     <= {w_ext, w_ext, b, 1'b0};
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_state    <= S_RUN;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                end
                S_RUN: begin
                    r_acc  <= w_acc_next;
                    r_mreg <= r_mreg >> 2;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NDIG - 1)) r_state <= S_DONE;
                end
                S_DONE: if (!r_out_valid) begin
                    r_product   <= r_acc[2*WIDTH-1:0];
                    r_out_valid <= 1'b1;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = r_busy;
endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: table-driven and scoreboard checks of booth_seq_mul (honours BOOTH_SIGNED_EN)
module tb_booth_seq_mul;
    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic [27:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] a;
    logic [13:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [27:0] product;
    logic        busy;
    logic [27:0] q[$];
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vt[6];

    booth_seq_mul #(.WIDTH(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] model(input logic [13:0] x, input logic [13:0] y);
        logic signed [27:0] sx;
        logic signed [27:0] sy;
`ifdef BOOTH_SIGNED_EN
        sx = {{14{x[13]}}, x};
        sy = {{14{y[13]}}, y};
`else
        sx = {14'b0, x};
        sy = {14'b0, y};
`endif
        return 28'(sx * sy);
    endfunction

    task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [13:0] ta, input logic [13:0] tb, input logic [27:0] te, input int hold);
        int n;
        logic [27:0] e;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_idle", 28'(in_ready), 28'd1);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 14'($urandom);
        b = 14'($urandom);
        q.push_back(te);
        check("busy_run", 28'(busy), 28'd1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = q.pop_front();
        if (n >= 50) begin
            check("timeout", 28'(out_valid), 28'd1);
            return;
        end
        check("latency", 28'(n), 28'd9);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 28'(out_valid), 28'd1);
            check("hold_prod", product, e);
            check("hold_in_ready", 28'(in_ready), 28'd0);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("product", product, e);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", 28'(out_valid), 28'd0);
        check("in_ready_back", 28'(in_ready), 28'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #3;
        check("rst_in_ready", 28'(in_ready), 28'd1);
        check("rst_out_valid", 28'(out_valid), 28'd0);
        check("rst_product", product, 28'd0);
        check("rst_busy", 28'(busy), 28'd0);
        @(negedge clk);
        rst = 1'b0;
`ifdef BOOTH_SIGNED_EN
        vt[0] = '{14'd3, 14'd5, 28'd15};
        vt[1] = '{14'h3FFD, 14'd5, 28'hFFFFFF1};
        vt[2] = '{14'h2000, 14'h2000, 28'd67108864};
        vt[3] = '{14'd0, 14'd12345, 28'd0};
        vt[4] = '{14'd12345, 14'd0, 28'd0};
        vt[5] = '{14'h3FFF, 14'h3FFF, 28'd1};
`else
        vt[0] = '{14'd3, 14'd5, 28'd15};
        vt[1] = '{14'd16383, 14'd16383, 28'hFFF8001};
        vt[2] = '{14'd0, 14'd12345, 28'd0};
        vt[3] = '{14'd12345, 14'd0, 28'd0};
        vt[4] = '{14'd7, 14'd9, 28'd63};
        vt[5] = '{14'd1, 14'd16383, 28'd16383};
`endif
        for (int i = 0; i < 6; i++) do_op(vt[i].a, vt[i].b, vt[i].exp, 0);
        do_op(14'd100, 14'd200, model(14'd100, 14'd200), 5);
        do_op(14'd3, 14'd5, 28'd15, 0);
        @(negedge clk);
        a = 14'd1234;
        b = 14'd4321;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 28'(in_ready), 28'd1);
        check("mid_rst_out_valid", 28'(out_valid), 28'd0);
        check("mid_rst_product", product, 28'd0);
        check("mid_rst_busy", 28'(busy), 28'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(14'd7, 14'd9, 28'd63, 0);
        for (int i = 0; i < 12; i++) begin
            logic [13:0] ra;
            logic [13:0] rb;
            ra = 14'($urandom);
            rb = 14'($urandom);
            do_op(ra, rb, model(ra, rb), int'($urandom_range(0, 2)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
